// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants, opcodes and fetch queue entry type for the 5-bit-opcode core
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INS_BUBBLE       = 32'h0000_0000;
    localparam logic [XLEN-1:0] INS_BYTES        = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_BLT  = 5'b10001;
    localparam logic [4:0] OP_BEQ  = 5'b10010;
    localparam logic [4:0] OP_JAL  = 5'b10011;
    localparam logic [4:0] OP_JALR = 5'b10100;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH x WIDTH synchronous FIFO with push/pop/flush and occupancy outputs
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == DEPTH_W);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with prefetch queue and IF/ID register; FETCH_PERF_EN adds perf counters
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_ins
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_bubble_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] QDEPTH_W = (CW+1)'(QDEPTH);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_discard;
    logic            r_ifid_valid;
    logic [XLEN-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_ins;

    logic            w_req_fire;
    logic            w_rsp_fire;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_load;
    logic [CW-1:0]   w_out_next;
    logic [CW:0]     w_credit_used;

    logic [CW-1:0]   w_af_count;
    logic            w_af_empty;
    logic            w_af_full;
    logic [XLEN-1:0] w_af_addr;

    logic [CW-1:0]   w_q_count;
    logic            w_q_empty;
    logic            w_q_full;
    fetch_entry_t    w_q_head;
    fetch_entry_t    w_q_in;

    // The in-flight address FIFO occupancy is the outstanding request count.
    assign w_credit_used  = {1'b0, w_af_count} + {1'b0, w_q_count};
    assign imem_req_valid = rst_n & ~w_af_full & (w_credit_used < QDEPTH_W);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;
    assign w_rsp_fire     = imem_rsp_valid & ~w_af_empty;
    assign w_out_next     = w_af_count + CW'(w_req_fire) - CW'(w_rsp_fire);

    assign w_drop = (r_discard != '0) | redirect_valid;
    assign w_push = w_rsp_fire & ~w_drop & ~w_q_full;
    assign w_load = ~stall & ~redirect_valid;
    assign w_pop  = w_load & ~w_q_empty;

    assign w_q_in.pc  = w_af_addr;
    assign w_q_in.ins = imem_rsp_data;

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (XLEN)
    ) u_addr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_fire),
        .i_data  (r_pc),
        .i_pop   (w_rsp_fire),
        .i_flush (1'b0),
        .o_data  (w_af_addr),
        .o_count (w_af_count),
        .o_empty (w_af_empty),
        .o_full  (w_af_full)
    );

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_prefetch_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_q_in),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_data  (w_q_head),
        .o_count (w_q_count),
        .o_empty (w_q_empty),
        .o_full  (w_q_full)
    );

    // A request accepted in the redirect cycle still targets the old path, so it is discarded too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_discard <= '0;
        end else begin
            if (redirect_valid) begin
                r_pc      <= redirect_pc & PC_ALIGN_MASK;
                r_discard <= w_out_next;
            end else begin
                if (w_req_fire) r_pc <= r_pc + INS_BYTES;
                if (w_rsp_fire && (r_discard != '0)) r_discard <= r_discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_ins   <= INS_BUBBLE;
        end else if (redirect_valid) begin
            r_ifid_valid <= 1'b0;
            r_ifid_ins   <= INS_BUBBLE;
        end else if (!stall) begin
            if (!w_q_empty) begin
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= w_q_head.pc;
                r_ifid_ins   <= w_q_head.ins;
            end else begin
                r_ifid_valid <= 1'b0;
                r_ifid_ins   <= INS_BUBBLE;
            end
        end
    end

    assign ifid_valid = r_ifid_valid;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_ins   = r_ifid_ins;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_bubble;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_bubble <= '0;
            r_perf_flush  <= '0;
        end else begin
            if (w_load && w_q_empty) r_perf_bubble <= r_perf_bubble + 32'd1;
            if (redirect_valid)      r_perf_flush  <= r_perf_flush + 32'd1;
        end
    end

    assign perf_bubble_cnt = r_perf_bubble;
    assign perf_flush_cnt  = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (optionally with FETCH_PERF_EN)
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ready, redirect_valid, stall;
    logic [31:0] redirect_pc;
    logic        rv, ifid_valid;
    logic [31:0] addr, ifid_pc, ifid_ins;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    int          lat = 1;

    logic        rv2, ifid_valid2, r2_v;
    logic [31:0] addr2, ifid_pc2, ifid_ins2, r2_a;

    logic        s1_v, s2_v;
    logic [31:0] s1_a, s2_a;
    int          infl, max_infl;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_next;
    int          bub, flushes, loads;
    logic [31:0] fires2[$];
    logic [31:0] pcs2[$];
    logic [31:0] ins2[$];

`ifdef FETCH_PERF_EN
    logic [31:0] pb, pf, pb2, pf2;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(rv), .imem_req_addr(addr), .imem_req_ready(ready),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_ins(ifid_ins)
`ifdef FETCH_PERF_EN
        , .perf_bubble_cnt(pb), .perf_flush_cnt(pf)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(rv2), .imem_req_addr(addr2), .imem_req_ready(1'b1),
        .imem_rsp_valid(r2_v), .imem_rsp_data(r2_a | 32'h2),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .stall(1'b0),
        .ifid_valid(ifid_valid2), .ifid_pc(ifid_pc2), .ifid_ins(ifid_ins2)
`ifdef FETCH_PERF_EN
        , .perf_bubble_cnt(pb2), .perf_flush_cnt(pf2)
`endif
    );

    // imem model: in-order, fixed latency (1 or 2), data = addr | 2
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0; s2_v <= 1'b0; s1_a <= '0; s2_a <= '0; infl <= 0;
            r2_v <= 1'b0; r2_a <= '0;
        end else begin
            s1_v <= rv & ready; s1_a <= addr;
            s2_v <= s1_v;       s2_a <= s1_a;
            infl <= infl + int'(rv & ready) - int'(rsp_valid);
            r2_v <= rv2;        r2_a <= addr2;
        end
    end
    assign rsp_valid = (lat == 2) ? s2_v : s1_v;
    assign rsp_data  = ((lat == 2) ? s2_a : s1_a) | 32'h2;

    initial max_infl = 0;
    always @(negedge clk) if (infl > max_infl) max_infl = infl;
    always @(posedge clk) if (rst_n && rv2) fires2.push_back(addr2);
    always @(negedge clk) if (rst_n && ifid_valid2) begin
        pcs2.push_back(ifid_pc2);
        ins2.push_back(ifid_ins2);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic ld, rd;
        ld = !stall && !redirect_valid;
        rd = redirect_valid;
        @(posedge clk);
        @(negedge clk);
        if (rd) flushes++;
        if (ld) begin
            if (ifid_valid) begin
                chk("sb_pc", ifid_pc, exp_next);
                chk("sb_ins", ifid_ins, exp_next | 32'h2);
                exp_next += 32'd4;
                loads++;
            end else begin
                bub++;
            end
        end
    endtask

    task automatic wait_load(input string name);
        int l0;
        int n;
        l0 = loads;
        n = 0;
        while (loads == l0 && n < 30) begin
            tick();
            n++;
        end
        chk(name, 32'(loads != l0), 32'd1);
    endtask

    task automatic do_reset(input int l);
        rst_n = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ready = 1'b1;
        #1;
        chk("rst_req_valid", 32'(rv), 32'd0);
        chk("rst_ifid_valid", 32'(ifid_valid), 32'd0);
        chk("rst_ifid_pc", ifid_pc, 32'h0);
        chk("rst_ifid_ins", ifid_ins, 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_addr2", addr2, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_EN
        chk("rst_perf_bubble", pb, 32'h0);
        chk("rst_perf_flush", pf, 32'h0);
`endif
        lat = l;
        @(negedge clk);
        @(negedge clk);
        fires2.delete(); pcs2.delete(); ins2.delete();
        exp_next = 32'h0; bub = 0; flushes = 0; loads = 0;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        ready;
        logic        rv;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
    } vec_t;

    vec_t tv[9];

    initial begin
        tv[0] = '{1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  32'h0};
        tv[1] = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0,  32'h0};
        tv[2] = '{1'b0, 1'b1, 1'b0, 32'd8,  1'b0, 32'd0,  32'h0};
        tv[3] = '{1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0,  32'h2};
        tv[4] = '{1'b0, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4,  32'h6};
        tv[5] = '{1'b0, 1'b1, 1'b0, 32'd16, 1'b0, 32'd4,  32'h0};
        tv[6] = '{1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8,  32'hA};
        tv[7] = '{1'b0, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12, 32'hE};
        tv[8] = '{1'b0, 1'b1, 1'b0, 32'd24, 1'b0, 32'd12, 32'h0};

        do_reset(1);

        // Test 1: streaming from RESET_PC with 1-cycle imem
        for (int i = 0; i < 9; i++) begin
            stall = tv[i].stall;
            ready = tv[i].ready;
            #1;
            chk($sformatf("t1[%0d].req_valid", i), 32'(rv), 32'(tv[i].rv));
            chk($sformatf("t1[%0d].req_addr", i), addr, tv[i].addr);
            chk($sformatf("t1[%0d].ifid_valid", i), 32'(ifid_valid), 32'(tv[i].v));
            chk($sformatf("t1[%0d].ifid_pc", i), ifid_pc, tv[i].pc);
            chk($sformatf("t1[%0d].ifid_ins", i), ifid_ins, tv[i].ins);
            tick();
`ifdef FETCH_PERF_EN
            if (i == 2) chk("t6_perf_init_bubbles", pb2, 32'd2);
`endif
        end

        // Test 6: wrap of the fetch PC from RESET_PC=FFFF_FFF8
        chk("t6_nfires", 32'(fires2.size() >= 3), 32'd1);
        chk("t6_fire0", fires2[0], 32'hFFFF_FFF8);
        chk("t6_fire1", fires2[1], 32'hFFFF_FFFC);
        chk("t6_fire2", fires2[2], 32'h0000_0000);
        chk("t6_npcs", 32'(pcs2.size() >= 3), 32'd1);
        chk("t6_pc0", pcs2[0], 32'hFFFF_FFF8);
        chk("t6_pc1", pcs2[1], 32'hFFFF_FFFC);
        chk("t6_pc2", pcs2[2], 32'h0000_0000);
        chk("t6_ins2", ins2[2], 32'h0000_0002);

        // Test 2: stall holds IF/ID (pc 16 loaded), then stream resumes at 20
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_hold_valid", 32'(ifid_valid), 32'd1);
            chk("t2_hold_pc", ifid_pc, 32'd16);
            chk("t2_hold_ins", ifid_ins, 32'h12);
        end
        stall = 1'b0;
        tick();
        chk("t2_resume_valid", 32'(ifid_valid), 32'd1);
        for (int i = 0; i < 8; i++) tick();

        // Test 3: mid-stream reset, 2-cycle imem, redirect with 2 requests in flight
        do_reset(2);
        tick();
        tick();
        chk("t3_credit_full", 32'(rv), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        exp_next = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("t3_flush_valid", 32'(ifid_valid), 32'd0);
        chk("t3_refetch_valid", 32'(rv), 32'd1);
        chk("t3_refetch_addr", addr, 32'h0000_0100);
        wait_load("t3_first_load");
        for (int i = 0; i < 6; i++) tick();

        // Test 4: redirect and stall together (target low bits ignored)
        stall = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        exp_next = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("t4_ifid_valid", 32'(ifid_valid), 32'd0);
        chk("t4_ifid_ins", ifid_ins, 32'h0);
        chk("t4_refetch_valid", 32'(rv), 32'd1);
        chk("t4_refetch_addr", addr, 32'h0000_0100);
        stall = 1'b0;
        wait_load("t4_first_load");

        // Test 5: imem back-pressure holds the address, IF/ID drains to bubbles
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_req_valid", 32'(rv), 32'd1);
            chk("t5_req_addr", addr, 32'h0000_0108);
            tick();
        end
        chk("t5_drained", 32'(ifid_valid), 32'd0);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        chk("max_inflight", 32'(max_infl <= 2), 32'd1);
`ifdef FETCH_PERF_EN
        chk("perf_bubble", pb, 32'(bub));
        chk("perf_flush", pf, 32'(flushes));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
